// File: rtl/matrix_pkg.sv
// Types and constants shared by the matrix row sequencers (sub now; add and
// scalar-multiply later). Rows are 5 packed signed 8-bit elements.
package matrix_pkg;

    localparam int ROW_W    = 40;
    localparam int ELEM_W   = 8;
    localparam int ROWS_DEF = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        OP   = 3'd2,
        EX   = 3'd3,
        WB   = 3'd4,
        DONE = 3'd5
    } seq_state_t;

endpackage

// File: rtl/matrix_row_sequencer.sv
// Reads A/B row pairs, feeds the external registered row ALU and writes each
// result row back. Optional MATSEQ_OVF_ABORT_EN stops the run at the first ALU overflow.
module matrix_row_sequencer
    import matrix_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int ROW_W = matrix_pkg::ROW_W,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    input  logic [ROW_W-1:0] a_row,
    input  logic [ROW_W-1:0] b_row,
    output logic [ROW_W-1:0] alu_m1,
    output logic [ROW_W-1:0] alu_m2,
    input  logic [ROW_W-1:0] alu_res,
    input  logic             alu_ovf,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [ROW_W-1:0] wr_data
);

    seq_state_t       state_q, state_d;
    logic [AW-1:0]    row_q, row_d;
    logic             ovf_q, ovf_d;
    logic [ROW_W-1:0] m1_q, m1_d;
    logic [ROW_W-1:0] m2_q, m2_d;
    logic             last_row;
    logic             abort_row;

    assign last_row = (row_q == AW'(ROWS - 1));

`ifdef MATSEQ_OVF_ABORT_EN
    assign abort_row = alu_ovf;
`else
    assign abort_row = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RD;
            RD:      state_d = OP;
            OP:      state_d = EX;
            EX:      state_d = WB;
            WB:      state_d = (last_row || abort_row) ? DONE : RD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        rd_en   = (state_q == RD);
        rd_addr = rd_en ? row_q : '0;
        wr_en   = (state_q == WB) && !abort_row;
        wr_addr = wr_en ? row_q : '0;
        wr_data = wr_en ? alu_res : '0;
        ovf     = ovf_q;
        alu_m1  = m1_q;
        alu_m2  = m2_q;
    end

    // Operand registers only load in OP, so they hold across EX and between runs.
    always_comb begin
        row_d = row_q;
        ovf_d = ovf_q;
        m1_d  = m1_q;
        m2_d  = m2_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d = '0;
                    ovf_d = 1'b0;
                end
            end
            OP: begin
                m1_d = a_row;
                m2_d = b_row;
            end
            WB: begin
                ovf_d = ovf_q | alu_ovf;
                if (!last_row) row_d = row_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            ovf_q <= 1'b0;
            m1_q  <= '0;
            m2_q  <= '0;
        end else begin
            row_q <= row_d;
            ovf_q <= ovf_d;
            m1_q  <= m1_d;
            m2_q  <= m2_d;
        end
    end

endmodule

// File: tb/tb_matrix_row_sequencer.sv
// Scoreboard bench for matrix_row_sequencer with behavioural operand memory and
// registered subtracting row ALU. Honours MATSEQ_OVF_ABORT_EN when defined.
module tb_matrix_row_sequencer;

    localparam int ROWS = 5;
    localparam int RW   = 40;
    localparam int AW   = 3;

`ifdef MATSEQ_OVF_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          start   = 1'b0;
    logic          busy, done, ovf, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [RW-1:0] a_row   = '0;
    logic [RW-1:0] b_row   = '0;
    logic [RW-1:0] alu_res = '0;
    logic          alu_ovf = 1'b0;
    logic [RW-1:0] alu_m1, alu_m2, wr_data;

    logic [RW-1:0]    mem_a [ROWS];
    logic [RW-1:0]    mem_b [ROWS];
    logic [AW+RW-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    matrix_row_sequencer #(.ROWS(ROWS), .ROW_W(RW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .ovf(ovf), .rd_en(rd_en), .rd_addr(rd_addr), .a_row(a_row),
        .b_row(b_row), .alu_m1(alu_m1), .alu_m2(alu_m2), .alu_res(alu_res),
        .alu_ovf(alu_ovf), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] sub_row(input logic [RW-1:0] a, input logic [RW-1:0] b);
        logic [RW-1:0] r;
        for (int e = 0; e < RW / 8; e++) r[e*8 +: 8] = a[e*8 +: 8] - b[e*8 +: 8];
        return r;
    endfunction

    function automatic logic sub_ovf(input logic [RW-1:0] a, input logic [RW-1:0] b);
        logic       o;
        logic [7:0] x, y, d;
        o = 1'b0;
        for (int e = 0; e < RW / 8; e++) begin
            x = a[e*8 +: 8];
            y = b[e*8 +: 8];
            d = x - y;
            if ((x[7] != y[7]) && (d[7] != x[7])) o = 1'b1;
        end
        return o;
    endfunction

    // Operand memory: one-cycle registered read; row ALU: one-cycle registered subtract.
    always @(posedge clk) begin
        if (rd_en) begin
            a_row <= mem_a[int'(rd_addr)];
            b_row <= mem_b[int'(rd_addr)];
        end
        alu_res <= sub_row(alu_m1, alu_m2);
        alu_ovf <= sub_ovf(alu_m1, alu_m2);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},    64'(busy),    64'd0);
        chk({tag, "_done"},    64'(done),    64'd0);
        chk({tag, "_ovf"},     64'(ovf),     64'd0);
        chk({tag, "_rd_en"},   64'(rd_en),   64'd0);
        chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        chk({tag, "_alu_m1"},  64'(alu_m1),  64'd0);
        chk({tag, "_alu_m2"},  64'(alu_m2),  64'd0);
        chk({tag, "_wr_en"},   64'(wr_en),   64'd0);
        chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    endtask

    task automatic fill(input logic [RW-1:0] a, input logic [RW-1:0] b);
        for (int r = 0; r < ROWS; r++) begin
            mem_a[r] = a;
            mem_b[r] = b;
        end
    endtask

    function automatic int first_ovf();
        for (int r = 0; r < ROWS; r++) if (sub_ovf(mem_a[r], mem_b[r])) return r;
        return -1;
    endfunction

    task automatic push_expected(input int n_rows);
        for (int r = 0; r < n_rows; r++) begin
            if (ABORT && sub_ovf(mem_a[r], mem_b[r])) break;
            exp_q.push_back({AW'(r), sub_row(mem_a[r], mem_b[r])});
        end
    endtask

    // Cycle 0 is the cycle start is driven; each loop step samples cycle c mid-period.
    task automatic run_op(input int exp_done, input int ovf_from, input logic [31:0] mask,
                          input int stop_cyc);
        int               row;
        logic [AW+RW-1:0] e;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= exp_done + 1; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == stop_cyc) return;
            chk("busy",  64'(busy),  64'(c <= exp_done));
            chk("done",  64'(done),  64'(c == exp_done));
            chk("ovf",   64'(ovf),   64'(ovf_from > 0 && c >= ovf_from));
            chk("rd_en", 64'(rd_en), 64'((c % 4 == 1) && (c < exp_done)));
            chk("rd_wr_excl", 64'(rd_en & wr_en), 64'd0);
            if (rd_en) chk("rd_addr", 64'(rd_addr), 64'((c - 1) / 4));
            if ((c % 4 == 3) && (c < exp_done)) begin
                row = (c - 3) / 4;
                chk("alu_m1", 64'(alu_m1), 64'(mem_a[row]));
                chk("alu_m2", 64'(alu_m2), 64'(mem_b[row]));
            end
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 64'(wr_addr), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(e[AW+RW-1:RW]));
                    chk("wr_data", 64'(wr_data), 64'(e[RW-1:0]));
                end
            end
            if (c < 32 && mask[c]) start = 1'b1;
        end
        start = 1'b0;
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_full(input string name, input logic [31:0] mask);
        int f;
        int exp_done;
        int ovf_from;
        f        = first_ovf();
        exp_done = (ABORT && f >= 0) ? 4 * f + 5 : 4 * ROWS + 1;
        ovf_from = (f >= 0) ? 4 * f + 5 : -1;
        push_expected(ROWS);
        run_op(exp_done, ovf_from, mask, 0);
        $display("run %s: done_cycle=%0d ovf_row=%0d checks=%0d errors=%0d",
                 name, exp_done, f, checks, errors);
    endtask

    initial begin
        logic [63:0] rnd_a, rnd_b;
        fill(40'h0A0A0A0A0A, 40'h0303030303);
        #2 rst_n = 1'b0;
        #1 check_zero("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_full("basic", 32'd0);

        mem_a[2] = 40'h800A0A0A0A;
        mem_b[2] = 40'h0103030303;
        run_full("ovf_row2", 32'd0);
        @(negedge clk);
        chk("ovf_hold_idle", 64'(ovf), 64'd1);

        fill(40'h0A0A0A0A0A, 40'h0303030303);
        run_full("ovf_clear_restart", 32'd0);

        run_full("start_while_busy", (32'd1 << 5) | (32'd1 << 21));

        for (int r = 0; r < ROWS; r++) begin
            rnd_a    = {$urandom, $urandom};
            rnd_b    = {$urandom, $urandom};
            mem_a[r] = rnd_a[RW-1:0];
            mem_b[r] = rnd_b[RW-1:0];
        end
        mem_a[0] = 40'h80FF7F0001;
        mem_b[0] = 40'h0000000000;
        run_full("pass_through_random", 32'd0);

        fill(40'h0A0A0A0A0A, 40'h0303030303);
        push_expected(2);
        run_op(4 * ROWS + 1, -1, 32'd0, 10);
        rst_n = 1'b0;
        #1 check_zero("rst_mid");
        chk("sb_mid", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        $display("run reset_mid_op: checks=%0d errors=%0d", checks, errors);
        run_full("after_reset", 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
